// File: rtl/sub_pipe_64bit.sv
// rtl/sub_pipe_64bit.sv - 4-stage pipelined 64-bit subtractor with per-stage valid tracking
//
// Computes result = mina - subb one STG_WIDTH slice per pipeline stage.
// The borrow ripples stage to stage, and each stage only advances when its
// input valid is set, so i_en bubbles never mix borrows between operations.
// DATA_WIDTH must equal 4*STG_WIDTH.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   i_en    operand valid; mina/subb sampled when high
//   mina    minuend
//   subb    subtrahend
//   result  {borrow_out, difference}, borrow_out=1 iff mina < subb (unsigned)
//   o_ovf   two's-complement overflow of the difference
//   o_en    result/o_ovf valid, one cycle per accepted operand pair,
//           4 cycles after the sampling edge
module sub_pipe_64bit #(
   parameter int DATA_WIDTH = 64,
   parameter int STG_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_en,
   input  logic [DATA_WIDTH-1:0] mina,
   input  logic [DATA_WIDTH-1:0] subb,
   output logic [DATA_WIDTH:0]   result,
   output logic                  o_ovf,
   output logic                  o_en
);

   localparam int S = STG_WIDTH;

   // per-stage valid bits
   logic v0_q, v1_q, v2_q, v3_q;

   // slice differences and borrows
   logic [S-1:0] d0_q, d1_q, d2_q, d3_q;
   logic         b0_q, b1_q, b2_q, b3_q;

   // upper-slice operands delayed so they meet the borrow of the same op
   logic [S-1:0] a1_q, s1_q;
   logic [S-1:0] a2_q [0:1];
   logic [S-1:0] s2_q [0:1];
   logic [S-1:0] a3_q [0:2];
   logic [S-1:0] s3_q [0:2];

   // lower difference slices delayed to line up with d3
   logic [S-1:0] d0_p1_q, d0_p2_q, d0_p3_q;
   logic [S-1:0] d1_p2_q, d1_p3_q;
   logic [S-1:0] d2_p3_q;

   // operand sign bits travelling alongside stage 3
   logic         sa3_q, sb3_q;

   // output stage
   logic [DATA_WIDTH:0] result_q;
   logic                ovf_q;
   logic                en_q;

   // next-state stage arithmetic, 17-bit so bit S is the borrow
   logic [S:0] st0_d, st1_d, st2_d, st3_d;
   logic       ovf_d;

   always_comb begin
      st0_d = {1'b0, mina[S-1:0]} - {1'b0, subb[S-1:0]};
      st1_d = {1'b0, a1_q}    - {1'b0, s1_q}    - {{S{1'b0}}, b0_q};
      st2_d = {1'b0, a2_q[1]} - {1'b0, s2_q[1]} - {{S{1'b0}}, b1_q};
      st3_d = {1'b0, a3_q[2]} - {1'b0, s3_q[2]} - {{S{1'b0}}, b2_q};
      // operands of different sign whose difference sign differs from the minuend
      ovf_d = (sa3_q != sb3_q) && (d3_q[S-1] != sa3_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0_q     <= 1'b0;
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         v3_q     <= 1'b0;
         d0_q     <= '0;
         d1_q     <= '0;
         d2_q     <= '0;
         d3_q     <= '0;
         b0_q     <= 1'b0;
         b1_q     <= 1'b0;
         b2_q     <= 1'b0;
         b3_q     <= 1'b0;
         a1_q     <= '0;
         s1_q     <= '0;
         a2_q[0]  <= '0;
         a2_q[1]  <= '0;
         s2_q[0]  <= '0;
         s2_q[1]  <= '0;
         a3_q[0]  <= '0;
         a3_q[1]  <= '0;
         a3_q[2]  <= '0;
         s3_q[0]  <= '0;
         s3_q[1]  <= '0;
         s3_q[2]  <= '0;
         d0_p1_q  <= '0;
         d0_p2_q  <= '0;
         d0_p3_q  <= '0;
         d1_p2_q  <= '0;
         d1_p3_q  <= '0;
         d2_p3_q  <= '0;
         sa3_q    <= 1'b0;
         sb3_q    <= 1'b0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         en_q     <= 1'b0;
      end else begin
         v0_q <= i_en;
         v1_q <= v0_q;
         v2_q <= v1_q;
         v3_q <= v2_q;

         // operand delay lines shift unconditionally; position k always
         // holds the operands sampled k cycles ago, valid or not
         a1_q    <= mina[2*S-1 -: S];
         s1_q    <= subb[2*S-1 -: S];
         a2_q[0] <= mina[3*S-1 -: S];
         s2_q[0] <= subb[3*S-1 -: S];
         a2_q[1] <= a2_q[0];
         s2_q[1] <= s2_q[0];
         a3_q[0] <= mina[4*S-1 -: S];
         s3_q[0] <= subb[4*S-1 -: S];
         a3_q[1] <= a3_q[0];
         s3_q[1] <= s3_q[0];
         a3_q[2] <= a3_q[1];
         s3_q[2] <= s3_q[1];

         if (i_en) begin
            {b0_q, d0_q} <= st0_d;
         end
         if (v0_q) begin
            {b1_q, d1_q} <= st1_d;
            d0_p1_q      <= d0_q;
         end
         if (v1_q) begin
            {b2_q, d2_q} <= st2_d;
            d0_p2_q      <= d0_p1_q;
            d1_p2_q      <= d1_q;
         end
         if (v2_q) begin
            {b3_q, d3_q} <= st3_d;
            d0_p3_q      <= d0_p2_q;
            d1_p3_q      <= d1_p2_q;
            d2_p3_q      <= d2_q;
            sa3_q        <= a3_q[2][S-1];
            sb3_q        <= s3_q[2][S-1];
         end

         // result/o_ovf hold the last valid value through bubbles
         if (v3_q) begin
            result_q <= {b3_q, d3_q, d2_p3_q, d1_p3_q, d0_p3_q};
            ovf_q    <= ovf_d;
         end
         en_q <= v3_q;
      end
   end

   assign result = result_q;
   assign o_ovf  = ovf_q;
   assign o_en   = en_q;

endmodule

// File: tb/tb_sub_pipe_64bit.sv
// tb/tb_sub_pipe_64bit.sv - scoreboard bench for sub_pipe_64bit
module tb_sub_pipe_64bit;

   logic        clk;
   logic        rst_n;
   logic        i_en;
   logic [63:0] mina;
   logic [63:0] subb;
   logic [64:0] result;
   logic        o_ovf;
   logic        o_en;

   sub_pipe_64bit #(.DATA_WIDTH(64), .STG_WIDTH(16)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (i_en),
      .mina   (mina),
      .subb   (subb),
      .result (result),
      .o_ovf  (o_ovf),
      .o_en   (o_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [64:0] res;
      logic        ovf;
      int          due;
   } exp_t;

   exp_t        sb_q[$];
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   logic [64:0] last_res = '0;
   logic        last_ovf = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b);
      exp_t e;
      e.res = {1'b0, a} - {1'b0, b};
      e.ovf = (a[63] != b[63]) && (e.res[63] != a[63]);
      e.due = 0;
      return e;
   endfunction

   // output monitor: checks order, value, latency, and absence of spurious o_en
   always @(negedge clk) begin
      if (!rst_n) begin
         last_res = '0;
         last_ovf = 1'b0;
      end else if (o_en) begin
         if (sb_q.size() == 0) begin
            chk("spurious_o_en", 65'(o_en), 65'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("latency", 65'(cyc), 65'(e.due));
            chk("result", result, e.res);
            chk("o_ovf", 65'(o_ovf), 65'(e.ovf));
            last_res = e.res;
            last_ovf = e.ovf;
         end
      end else begin
         chk("hold_result", result, last_res);
         chk("hold_ovf", 65'(o_ovf), 65'(last_ovf));
         if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("missing_o_en", 65'(o_en), 65'd1);
         end
      end
   end

   // drive one cycle; an accepted op pushes its expectation, due 5 edges on
   // (1 edge to sample, 4 edges of latency) as seen at the following negedge
   task automatic drive(input logic en, input logic [63:0] a, input logic [63:0] b,
                        input logic [64:0] er, input logic eo);
      exp_t e;
      @(negedge clk);
      i_en = en;
      mina = a;
      subb = b;
      if (en) begin
         e.res = er;
         e.ovf = eo;
         e.due = cyc + 5;
         sb_q.push_back(e);
      end
   endtask

   task automatic op_exp(input logic [63:0] a, input logic [63:0] b,
                         input logic [64:0] er, input logic eo);
      drive(1'b1, a, b, er, eo);
   endtask

   task automatic op_model(input logic [63:0] a, input logic [63:0] b);
      exp_t e;
      e = model(a, b);
      drive(1'b1, a, b, e.res, e.ovf);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, '0, 1'b0);
   endtask

   initial begin
      int ops;
      logic [63:0] ra, rb;
      rst_n = 1'b0;
      i_en  = 1'b0;
      mina  = '0;
      subb  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_result", result, 65'd0);
      chk("reset_ovf", 65'(o_ovf), 65'd0);
      chk("reset_o_en", 65'(o_en), 65'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // single isolated op
      op_exp(64'h0000_0000_0001_0000, 64'h1, 65'h0_0000_0000_0000_FFFF, 1'b0);
      idle(6);

      // borrow-out and signed overflow corners
      op_exp(64'h0, 64'h1, 65'h1_FFFF_FFFF_FFFF_FFFF, 1'b0);
      op_exp(64'h8000_0000_0000_0000, 64'h1, 65'h0_7FFF_FFFF_FFFF_FFFF, 1'b1);
      op_exp(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 65'h1_0000_0000_0000_0001, 1'b0);
      op_exp(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 65'h0, 1'b0);
      idle(6);

      // back-to-back
      op_exp(64'd5, 64'd3, 65'h0_0000_0000_0000_0002, 1'b0);
      op_exp(64'd3, 64'd5, 65'h1_FFFF_FFFF_FFFF_FFFE, 1'b0);
      op_exp(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65'h1_8000_0000_0000_0000, 1'b1);
      idle(6);

      // gapped: borrow ripple through three slices, then x-x
      op_exp(64'h0001_0000_0000_0000, 64'h1, 65'h0_0000_FFFF_FFFF_FFFF, 1'b0);
      idle(2);
      op_exp(64'h5, 64'h5, 65'h0, 1'b0);
      idle(6);

      // reset with ops in flight
      op_model(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_0000_0002);
      op_model(64'h1, 64'h2);
      idle(2);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      chk("async_reset_result", result, 65'd0);
      chk("async_reset_ovf", 65'(o_ovf), 65'd0);
      chk("async_reset_o_en", 65'(o_en), 65'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(8);

      // random density stream vs. reference model
      ops = 0;
      while (ops < 10000) begin
         if ($urandom_range(0, 3) == 0) begin
            idle(1);
         end else begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
               0: rb = ra;
               1: ra = '0;
               2: rb = 64'hFFFF_FFFF_FFFF_FFFF;
               3: ra = {ra[63:16], 16'h0};
               default: ;
            endcase
            op_model(ra, rb);
            ops++;
         end
      end
      idle(8);
      chk("scoreboard_drained", 65'(sb_q.size()), 65'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
